bus_control_unit: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 16-bit processor datapath. It drives the 4-bit bus select that chooses which register drives the shared bus, and the one-hot register load enables that capture the bus value. It also drives ALU op, PC increment and the memory read/write handshake.
It sits directly upstream of the bus multiplexer and register file, and consumes IR contents, the ALU zero flag and memory ready.

---
 rtl/cpu_ctrl_pkg.sv | 71 +++++++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/bus_control_unit.sv | 160 ++++++++++++++++
 tb/tb_bus_control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the processor control sequencer: opcodes, bus source
// codes, load-enable bit positions, ALU ops and the sequencer state set.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JPNZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] BUS_RA = 4'b0000;
  localparam logic [3:0] BUS_RB = 4'b0001;
  localparam logic [3:0] BUS_RC = 4'b0010;
  localparam logic [3:0] BUS_R1 = 4'b0011;
  localparam logic [3:0] BUS_R2 = 4'b0100;
  localparam logic [3:0] BUS_R3 = 4'b0101;
  localparam logic [3:0] BUS_DR = 4'b0110;
  localparam logic [3:0] BUS_AR = 4'b0111;
  localparam logic [3:0] BUS_AC = 4'b1001;
  localparam logic [3:0] BUS_PC = 4'b1010;

  localparam int LD_AR = 0;
  localparam int LD_DR = 1;
  localparam int LD_IR = 2;
  localparam int LD_R1 = 3;
  localparam int LD_R2 = 4;
  localparam int LD_R3 = 5;
  localparam int LD_RA = 6;
  localparam int LD_RB = 7;
  localparam int LD_RC = 8;
  localparam int LD_AC = 9;
  localparam int LD_PC = 10;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_INC  = 2'b11;

  typedef enum logic [3:0] {
    FETCH_A, FETCH_M, FETCH_I, DECODE, OPR_A, OPR_M,
    EX1, EX2, EX3, HALT, FAULT
  } state_t;

  // Any of the ten defined bus sources may feed the ALU.
  function automatic logic bus_code_legal(input logic [3:0] code);
    return (code <= BUS_AR) || (code == BUS_AC) || (code == BUS_PC);
  endfunction

  // Load enable for a general-register destination; zero marks an illegal target.
  function automatic logic [10:0] gpr_ld_mask(input logic [3:0] code);
    logic [10:0] m;
    m = '0;
    case (code)
      BUS_RA:  m[LD_RA] = 1'b1;
      BUS_RB:  m[LD_RB] = 1'b1;
      BUS_RC:  m[LD_RC] = 1'b1;
      BUS_R1:  m[LD_R1] = 1'b1;
      BUS_R2:  m[LD_R2] = 1'b1;
      BUS_R3:  m[LD_R3] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been outstanding and flags the last
// allowed wait cycle so the sequencer can abandon the request.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(WAIT_LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || !req || ready) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

  // The cycle holding count LAST is the WAIT_LIMIT-th wait without ready.
  assign timeout = req && !ready && (count == LAST);

endmodule

// File: rtl/bus_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the shared-bus source
// select, register load enables, ALU op, PC increment and memory handshake.
module bus_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        z_flag,
  input  logic        mem_ready,
  output logic [3:0]  bus_sel,
  output logic [10:0] ld_en,
  output logic        pc_inc,
  output logic [1:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        fault
);

  state_t     state, state_d;
  logic       timeout;
  logic       mem_req;
  logic [3:0] op, rcode;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign rcode     = ir[11:8];
  assign unused_ir = ^ir[7:0];
  assign mem_req   = mem_rd | mem_wr;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_A;
    else     state <= state_d;
  end

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .req     (mem_req),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  // Outputs are forced idle while rst is high so a reset mid-request never loads.
  always_comb begin
    state_d = state;
    bus_sel = BUS_PC;
    ld_en   = '0;
    pc_inc  = 1'b0;
    alu_op  = ALU_PASS;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH_A, OPR_A: begin
          bus_sel      = BUS_PC;
          ld_en[LD_AR] = 1'b1;
          state_d      = (state == FETCH_A) ? FETCH_M : OPR_M;
        end
        FETCH_M, OPR_M: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ld_en[LD_DR] = 1'b1;
            pc_inc       = 1'b1;
            state_d      = (state == FETCH_M) ? FETCH_I : EX1;
          end else if (timeout) begin
            state_d = FAULT;
          end
        end
        FETCH_I: begin
          bus_sel      = BUS_DR;
          ld_en[LD_IR] = 1'b1;
          state_d      = DECODE;
        end
        DECODE: begin
          case (op)
            OP_NOP:                             state_d = FETCH_A;
            OP_LDAC, OP_STAC, OP_JMP, OP_JPNZ:  state_d = OPR_A;
            OP_MVAC, OP_ADD, OP_SUB:            state_d = bus_code_legal(rcode) ? EX1 : FAULT;
            OP_MOVR:                            state_d = (gpr_ld_mask(rcode) != '0) ? EX1 : FAULT;
            OP_INC:                             state_d = EX1;
            OP_HALT:                            state_d = HALT;
            default:                            state_d = FAULT;
          endcase
        end
        EX1: begin
          state_d = FETCH_A;
          case (op)
            OP_LDAC, OP_STAC: begin
              bus_sel      = BUS_DR;
              ld_en[LD_AR] = 1'b1;
              state_d      = EX2;
            end
            OP_MVAC, OP_ADD, OP_SUB: begin
              bus_sel      = rcode;
              alu_op       = (op == OP_ADD) ? ALU_ADD : (op == OP_SUB) ? ALU_SUB : ALU_PASS;
              ld_en[LD_AC] = 1'b1;
            end
            OP_INC: begin
              bus_sel      = BUS_AC;
              alu_op       = ALU_INC;
              ld_en[LD_AC] = 1'b1;
            end
            OP_MOVR: begin
              bus_sel = BUS_AC;
              ld_en   = gpr_ld_mask(rcode);
            end
            OP_JMP, OP_JPNZ: begin
              if (op == OP_JMP || !z_flag) begin
                bus_sel      = BUS_DR;
                ld_en[LD_PC] = 1'b1;
              end
            end
            default: state_d = FAULT;
          endcase
        end
        EX2: begin
          if (op == OP_LDAC) begin
            mem_rd = 1'b1;
            if (mem_ready) begin
              ld_en[LD_DR] = 1'b1;
              state_d      = EX3;
            end else if (timeout) begin
              state_d = FAULT;
            end
          end else begin
            bus_sel      = BUS_AC;
            ld_en[LD_DR] = 1'b1;
            state_d      = EX3;
          end
        end
        EX3: begin
          if (op == OP_LDAC) begin
            bus_sel      = BUS_DR;
            ld_en[LD_AC] = 1'b1;
            state_d      = FETCH_A;
          end else begin
            mem_wr = 1'b1;
            if (mem_ready)    state_d = FETCH_A;
            else if (timeout) state_d = FAULT;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        FAULT: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: state_d = FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_unit.sv
// Directed scoreboard bench: each instruction pushes its expected per-cycle
// control outputs, which are popped and compared one cycle at a time.
module tb_bus_control_unit;

  localparam logic [10:0] L_NONE = 11'h000;
  localparam logic [10:0] L_AR = 11'h001;
  localparam logic [10:0] L_DR = 11'h002;
  localparam logic [10:0] L_IR = 11'h004;
  localparam logic [10:0] L_R2 = 11'h010;
  localparam logic [10:0] L_RA = 11'h040;
  localparam logic [10:0] L_AC = 11'h200;
  localparam logic [10:0] L_PC = 11'h400;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [15:0] ir;
    logic        z;
    logic [3:0]  bus;
    logic [10:0] ld;
    logic        inc;
    logic [1:0]  alu;
    logic        rd;
    logic        wr;
    logic        hlt;
    logic        flt;
  } step_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        z_flag = 1'b0;
  logic        mem_ready = 1'b1;
  logic        rdy2 = 1'b0;
  logic [3:0]  bus_sel, bus2;
  logic [10:0] ld_en, ld2;
  logic        pc_inc, inc2, mem_rd, rd2, mem_wr, wr2, halted, hlt2, fault, flt2;
  logic [1:0]  alu_op, alu2;

  step_t       q[$];
  logic [15:0] cur_ir;
  logic        cur_z;
  int          errors = 0;
  int          checks = 0;
  int          step_no = 0;
  int          inc_seen = 0;

  always #5 clk = ~clk;

  bus_control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .z_flag(z_flag), .mem_ready(mem_ready),
    .bus_sel(bus_sel), .ld_en(ld_en), .pc_inc(pc_inc), .alu_op(alu_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .fault(fault)
  );

  bus_control_unit #(.WAIT_LIMIT(2)) dut2 (
    .clk(clk), .rst(rst), .ir(ir), .z_flag(z_flag), .mem_ready(rdy2),
    .bus_sel(bus2), .ld_en(ld2), .pc_inc(inc2), .alu_op(alu2),
    .mem_rd(rd2), .mem_wr(wr2), .halted(hlt2), .fault(flt2)
  );

  function automatic step_t mk(input logic r, input logic rdy, input logic [3:0] bus,
                               input logic [10:0] ld, input logic inc, input logic [1:0] alu,
                               input logic rd, input logic wr, input logic hlt, input logic flt);
    step_t s;
    s = '{rst: r, rdy: rdy, ir: cur_ir, z: cur_z, bus: bus, ld: ld, inc: inc, alu: alu,
          rd: rd, wr: wr, hlt: hlt, flt: flt};
    return s;
  endfunction

  task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word, input logic z);
    cur_ir   = word;
    cur_z    = z;
    inc_seen = 0;
  endtask

  task automatic pushOpr();
    q.push_back(mk(0, 1, 4'hA, L_AR, 0, 2'b00, 0, 0, 0, 0));
    q.push_back(mk(0, 1, 4'hA, L_DR, 1, 2'b00, 1, 0, 0, 0));
  endtask

  task automatic pushFetch();
    pushOpr();
    q.push_back(mk(0, 1, 4'h6, L_IR, 0, 2'b00, 0, 0, 0, 0));
    q.push_back(mk(0, 1, 4'hA, L_NONE, 0, 2'b00, 0, 0, 0, 0));
  endtask

  task automatic pushEx(input logic [3:0] bus, input logic [10:0] ld, input logic [1:0] alu);
    q.push_back(mk(0, 1, bus, ld, 0, alu, 0, 0, 0, 0));
  endtask

  task automatic pushReset();
    q.push_back(mk(1, 1, 4'hA, L_NONE, 0, 2'b00, 0, 0, 0, 0));
  endtask

  task automatic pushStop(input int n, input logic flt);
    for (int i = 0; i < n; i++) q.push_back(mk(0, 1, 4'hA, L_NONE, 0, 2'b00, 0, 0, 1, flt));
  endtask

  // Drive each queued step at the falling edge and compare the outputs just after.
  task automatic checkOutput();
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      rst       = e.rst;
      mem_ready = e.rdy;
      ir        = e.ir;
      z_flag    = e.z;
      #1;
      step_no++;
      if (pc_inc === 1'b1) inc_seen++;
      cmp($sformatf("s%0d bus_sel", step_no), 16'(bus_sel), 16'(e.bus));
      cmp($sformatf("s%0d ld_en", step_no), 16'(ld_en), 16'(e.ld));
      cmp($sformatf("s%0d pc_inc", step_no), 16'(pc_inc), 16'(e.inc));
      cmp($sformatf("s%0d alu_op", step_no), 16'(alu_op), 16'(e.alu));
      cmp($sformatf("s%0d mem_rd", step_no), 16'(mem_rd), 16'(e.rd));
      cmp($sformatf("s%0d mem_wr", step_no), 16'(mem_wr), 16'(e.wr));
      cmp($sformatf("s%0d halted", step_no), 16'(halted), 16'(e.hlt));
      cmp($sformatf("s%0d fault", step_no), 16'(fault), 16'(e.flt));
    end
  endtask

  initial begin
    applyStimulus(16'h3300, 1'b0);
    pushReset(); pushReset();
    checkOutput();

    pushFetch(); pushEx(4'h3, L_AC, 2'b00);
    checkOutput();
    cmp("mvac_pc_inc_count", 16'(inc_seen), 16'd1);

    applyStimulus(16'h5100, 1'b0); pushFetch(); pushEx(4'h1, L_AC, 2'b01); checkOutput();
    applyStimulus(16'h6500, 1'b0); pushFetch(); pushEx(4'h5, L_AC, 2'b10); checkOutput();
    applyStimulus(16'h7000, 1'b0); pushFetch(); pushEx(4'h9, L_AC, 2'b11); checkOutput();
    applyStimulus(16'h4400, 1'b0); pushFetch(); pushEx(4'h9, L_R2, 2'b00); checkOutput();
    applyStimulus(16'h4000, 1'b0); pushFetch(); pushEx(4'h9, L_RA, 2'b00); checkOutput();
    applyStimulus(16'h3A00, 1'b0); pushFetch(); pushEx(4'hA, L_AC, 2'b00); checkOutput();
    applyStimulus(16'h0000, 1'b0); pushFetch(); checkOutput();
    applyStimulus(16'h8000, 1'b1); pushFetch(); pushOpr(); pushEx(4'h6, L_PC, 2'b00); checkOutput();
    applyStimulus(16'h9000, 1'b0); pushFetch(); pushOpr(); pushEx(4'h6, L_PC, 2'b00); checkOutput();

    applyStimulus(16'h9000, 1'b1); pushFetch(); pushOpr(); pushEx(4'hA, L_NONE, 2'b00);
    checkOutput();
    cmp("jpnz_skip_pc_inc_count", 16'(inc_seen), 16'd2);

    // LDAC with the data read answered on its fourth request cycle.
    applyStimulus(16'h1000, 1'b0); pushFetch(); pushOpr(); pushEx(4'h6, L_AR, 2'b00);
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 4'hA, L_NONE, 0, 2'b00, 1, 0, 0, 0));
    q.push_back(mk(0, 1, 4'hA, L_DR, 0, 2'b00, 1, 0, 0, 0));
    pushEx(4'h6, L_AC, 2'b00);
    checkOutput();

    applyStimulus(16'h2000, 1'b0); pushFetch(); pushOpr();
    pushEx(4'h6, L_AR, 2'b00); pushEx(4'h9, L_DR, 2'b00);
    q.push_back(mk(0, 0, 4'hA, L_NONE, 0, 2'b00, 0, 1, 0, 0));
    q.push_back(mk(0, 1, 4'hA, L_NONE, 0, 2'b00, 0, 1, 0, 0));
    checkOutput();

    applyStimulus(16'hA000, 1'b0); pushFetch(); pushStop(3, 1'b1); pushReset(); checkOutput();
    applyStimulus(16'h4900, 1'b0); pushFetch(); pushStop(2, 1'b1); pushReset(); checkOutput();
    applyStimulus(16'h3800, 1'b0); pushFetch(); pushStop(2, 1'b1); pushReset(); checkOutput();

    // STAC interrupted by reset while its write is still waiting.
    applyStimulus(16'h2000, 1'b0); pushFetch(); pushOpr();
    pushEx(4'h6, L_AR, 2'b00); pushEx(4'h9, L_DR, 2'b00);
    q.push_back(mk(0, 0, 4'hA, L_NONE, 0, 2'b00, 0, 1, 0, 0));
    pushReset();
    checkOutput();
    applyStimulus(16'h3300, 1'b0); pushFetch(); pushEx(4'h3, L_AC, 2'b00); checkOutput();

    applyStimulus(16'hF000, 1'b0); pushFetch(); pushStop(100, 1'b0); checkOutput();

    // Short-limit instance never sees ready, so the first fetch read times out.
    @(negedge clk); rst = 1'b1; #1;
    cmp("d2 fault under reset", 16'(flt2), 16'd0);
    @(negedge clk); rst = 1'b0; #1;
    cmp("d2 c1 ld_en", 16'(ld2), 16'(L_AR));
    cmp("d2 c1 mem_rd", 16'(rd2), 16'd0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk); #1;
      cmp($sformatf("d2 c%0d mem_rd", c), 16'(rd2), 16'd1);
      cmp($sformatf("d2 c%0d ld_en", c), 16'(ld2), 16'(L_NONE));
      cmp($sformatf("d2 c%0d fault", c), 16'(flt2), 16'd0);
    end
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk); #1;
      cmp($sformatf("d2 c%0d fault", c), 16'(flt2), 16'd1);
      cmp($sformatf("d2 c%0d halted", c), 16'(hlt2), 16'd1);
      cmp($sformatf("d2 c%0d mem_rd", c), 16'(rd2), 16'd0);
      cmp($sformatf("d2 c%0d bus_sel", c), 16'(bus2), 16'hA);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
